// File: rtl/reg_slice_buf.sv
// reg_slice_buf: registered valid/ready FIFO buffer with flush, occupancy count and almost-full flag
module reg_slice_buf #(
  parameter type PLD_TYPE = logic,
  parameter int DEPTH = 2,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter bit NO_DATA_RESET = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  PLD_TYPE                    s_pld,
  input  logic                       s_vld,
  output logic                       s_rdy,
  output PLD_TYPE                    m_pld,
  output logic                       m_vld,
  input  logic                       m_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       afull
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic rst_lock, push, pop;
  PLD_TYPE mem [DEPTH];
  if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
    $error("reg_slice_buf: DEPTH must be in 2..64");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("reg_slice_buf: AFULL_THRESH must be in 1..DEPTH");
  end
  assign s_rdy = (count < CW'(DEPTH)) && rst_lock && ~flush;
  assign m_vld = count != '0;
  assign m_pld = mem[rd_ptr];
  assign afull = count >= CW'(AFULL_THRESH);
  assign push  = s_vld && s_rdy;
  assign pop   = m_vld && m_rdy;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // rst_lock keeps s_rdy low through the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_lock <= 1'b0;
    else rst_lock <= 1'b1;
  // pointers and occupancy; flush overrides push and pop in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  if (NO_DATA_RESET) begin : g_nrst
    // payload storage without reset, written on every accepted beat
    always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= s_pld;
  end else begin : g_rst
    // payload storage cleared on reset, written on every accepted beat
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (push) mem[wr_ptr] <= s_pld;
  end
endmodule

// File: tb/tb_reg_slice_buf.sv
// tb_reg_slice_buf: queue-model and directed checks over several depths of reg_slice_buf
module tb_reg_slice_buf;
  localparam int N = 5;
  localparam int DS [N] = '{4, 3, 2, 5, 8};
  localparam int TH [N] = '{3, 2, 1, 2, 8};
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, lock;
  logic sv [N], mr [N], fl [N], srdy [N], mv [N], af [N];
  logic [7:0] sp [N], mp [N];
  logic [3:0] cn [N];
  logic [7:0] q [N][$];
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [$clog2(DS[g]+1)-1:0] c;
    reg_slice_buf #(
      .PLD_TYPE(logic [7:0]), .DEPTH(DS[g]), .AFULL_THRESH(TH[g]), .NO_DATA_RESET(g == 3)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(fl[g]),
      .s_pld(sp[g]), .s_vld(sv[g]), .s_rdy(srdy[g]),
      .m_pld(mp[g]), .m_vld(mv[g]), .m_rdy(mr[g]),
      .count(c), .afull(af[g])
    );
    assign cn[g] = 4'(c);
  end
  task automatic chk(input string n, input int i, input int a, input int e);
    checks++;
    if (a !== e) $display("FAIL %s[%0d] got %0h exp %0h at %0t", n, i, a, e, $time);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // reference model: each buffer is an ordered queue of accepted beats
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) q[i].delete();
      lock <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        int n;
        n = q[i].size();
        if (mr[i] && n != 0) void'(q[i].pop_front());
        if (fl[i]) q[i].delete();
        else if (sv[i] && lock && n < DS[i]) q[i].push_back(sp[i]);
      end
      lock <= 1'b1;
    end
  // every-cycle comparison of all instances against the model
  always @(negedge clk)
    if (en)
      for (int i = 0; i < N; i++) begin
        chk("count", i, cn[i], q[i].size());
        chk("m_vld", i, mv[i], q[i].size() != 0);
        chk("s_rdy", i, srdy[i], q[i].size() < DS[i] && lock && !fl[i]);
        chk("afull", i, af[i], q[i].size() >= TH[i]);
        if (q[i].size() != 0) chk("m_pld", i, mp[i], q[i][0]);
      end
  initial begin
    for (int i = 0; i < N; i++) begin
      sv[i] = 0; mr[i] = 0; fl[i] = 0; sp[i] = 0;
    end
    #1 rst_n = 1'b0;
    en = 1'b1;
    sv[0] = 1; sp[0] = 8'h55;
    tick();
    chk("rst_s_rdy", 0, srdy[0], 0);
    chk("rst_m_vld", 0, mv[0], 0);
    chk("rst_count", 0, cn[0], 0);
    chk("rst_afull", 0, af[0], 0);
    chk("rst_count", 4, cn[4], 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("edge1_count", 0, cn[0], 0);
    chk("edge1_s_rdy", 0, srdy[0], 1);
    tick();
    chk("edge2_count", 0, cn[0], 1);
    chk("edge2_m_vld", 0, mv[0], 1);
    chk("edge2_m_pld", 0, mp[0], 8'h55);
    sv[0] = 0; mr[0] = 1;
    tick();
    chk("drain_count", 0, cn[0], 0);
    mr[0] = 0;
    for (int k = 0; k < 4; k++) begin
      sv[0] = 1; sp[0] = 8'hA1 + 8'(k);
      tick();
      chk("fill_count", 0, cn[0], k + 1);
      chk("fill_afull", 0, af[0], k + 1 >= 3);
    end
    chk("full_s_rdy", 0, srdy[0], 0);
    chk("full_m_pld", 0, mp[0], 8'hA1);
    sp[0] = 8'hB0; mr[0] = 1;
    tick();
    chk("fullpop_count", 0, cn[0], 3);
    chk("fullpop_m_pld", 0, mp[0], 8'hA2);
    chk("fullpop_s_rdy", 0, srdy[0], 1);
    tick();
    chk("pushpop_count", 0, cn[0], 3);
    chk("pushpop_m_pld", 0, mp[0], 8'hA3);
    sv[0] = 0;
    tick();
    chk("out_m_pld", 0, mp[0], 8'hA4);
    tick();
    chk("out_m_pld", 0, mp[0], 8'hB0);
    tick();
    chk("empty_m_vld", 0, mv[0], 0);
    mr[0] = 0; sv[0] = 1; sp[0] = 8'hC1;
    tick();
    sp[0] = 8'hC2;
    tick();
    chk("preflush_count", 0, cn[0], 2);
    fl[0] = 1; sp[0] = 8'hC3;
    #1 chk("flush_s_rdy", 0, srdy[0], 0);
    tick();
    chk("flush_count", 0, cn[0], 0);
    chk("flush_m_vld", 0, mv[0], 0);
    chk("flush_afull", 0, af[0], 0);
    fl[0] = 0; sv[0] = 0;
    sv[1] = 1; mr[1] = 1;
    for (int k = 0; k < 10; k++) begin
      sp[1] = 8'h10 + 8'(k);
      tick();
      chk("stream_count", 1, cn[1], 1);
      chk("stream_m_pld", 1, mp[1], 8'h10 + k);
    end
    sv[1] = 0;
    tick();
    chk("stream_end", 1, cn[1], 0);
    sv[0] = 1; mr[0] = 0; sp[0] = 8'hD1;
    tick();
    tick();
    chk("mid_count", 0, cn[0], 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", 0, cn[0], 0);
    chk("async_m_vld", 0, mv[0], 0);
    chk("async_s_rdy", 0, srdy[0], 0);
    sv[0] = 0; mr[0] = 1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_m_vld", 0, mv[0], 0);
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (c == 5000) rst_n = 1'b0;
      if (c == 5002) rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
        sv[i] = 1'($urandom_range(0, 1));
        mr[i] = 1'($urandom_range(0, 1));
        fl[i] = $urandom_range(0, 63) == 0;
        sp[i] = 8'($urandom);
      end
    end
    for (int i = 0; i < N; i++) begin
      sv[i] = 0; fl[i] = 0; mr[i] = 1;
    end
    repeat (10) tick();
    for (int i = 0; i < N; i++) chk("final_count", i, cn[i], 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
